// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
package mult_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned PASS_N = 4;
    localparam int unsigned PASS_W = 2;
    localparam int unsigned SH_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One entry per nibble pass: which operand halves feed the core and the partial-product shift
    typedef struct packed {
        logic            a_hi;
        logic            b_hi;
        logic [SH_W-1:0] shift;
    } pass_sel_t;

    localparam pass_sel_t PASS_TBL [PASS_N] = '{
        '{a_hi: 1'b0, b_hi: 1'b0, shift: 4'd0},
        '{a_hi: 1'b1, b_hi: 1'b0, shift: 4'd4},
        '{a_hi: 1'b0, b_hi: 1'b1, shift: 4'd4},
        '{a_hi: 1'b1, b_hi: 1'b1, shift: 4'd8}
    };

    // Pick the high or low nibble of an operand
    function automatic logic [NIB_W-1:0] nib(input logic [OP_W-1:0] v, input logic hi);
        return hi ? v[OP_W-1:NIB_W] : v[NIB_W-1:0];
    endfunction

endpackage

// File: rtl/main.sv
// Combinational 4x4 unsigned multiplier core.
module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);

    assign o = 8'(x) * 8'(y);

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 -> 16 multiplier built on one shared 4x4 core, four nibble passes per product.
module mult8_seq_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned TAG_W     = 2,
    parameter int unsigned ZERO_SKIP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_p,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    state_t              r_state;
    logic [PASS_W-1:0]   r_pass;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [TAG_W-1:0]    r_tag;
    logic [PROD_W-1:0]   r_acc;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [PROD_W-1:0]   r_out_p;
    logic [TAG_W-1:0]    r_out_tag;
    logic                r_busy;

    pass_sel_t           w_sel;
    logic [NIB_W-1:0]    w_x;
    logic [NIB_W-1:0]    w_y;
    logic [2*NIB_W-1:0]  w_o;
    logic [PROD_W-1:0]   w_sum;
    logic                w_zero_op;

    // Core operand mux; core inputs held at zero outside MUL to avoid needless toggling
    always_comb begin
        w_sel = PASS_TBL[r_pass];
        w_x   = '0;
        w_y   = '0;
        if (r_state == MUL) begin
            w_x = nib(r_a, w_sel.a_hi);
            w_y = nib(r_b, w_sel.b_hi);
        end
        w_sum     = r_acc + (PROD_W'(w_o) << w_sel.shift);
        w_zero_op = (ZERO_SKIP != 0) && ((in_a == '0) || (in_b == '0));
    end

    main u_core (
        .x (w_x),
        .y (w_y),
        .o (w_o)
    );

    // Controller: accept, four accumulate passes, hold result until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pass      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_tag       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_tag   <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_tag      <= in_tag;
                        r_acc      <= '0;
                        r_pass     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_zero_op) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_out_p     <= '0;
                            r_out_tag   <= in_tag;
                        end else begin
                            r_state <= MUL;
                        end
                    end
                end
                MUL: begin
                    r_acc  <= w_sum;
                    r_pass <= r_pass + 1'b1;
                    if (r_pass == PASS_W'(PASS_N - 1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_out_p     <= w_sum;
                        r_out_tag   <= r_tag;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign out_tag   = r_out_tag;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Bench for mult8_seq_ctrl: two instances (zero-skip on / off), a transaction-level model and per-cycle compare.
module tb_mult8_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  in_a      [2];
    logic [7:0]  in_b      [2];
    logic [1:0]  in_tag    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] out_p     [2];
    logic [1:0]  out_tag   [2];
    logic        busy      [2];

    int n_checks;
    int n_pass;

    mult8_seq_ctrl #(.TAG_W(2), .ZERO_SKIP(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_tag(in_tag[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_p(out_p[0]), .out_tag(out_tag[0]), .busy(busy[0])
    );

    mult8_seq_ctrl #(.TAG_W(2), .ZERO_SKIP(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_tag(in_tag[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_p(out_p[1]), .out_tag(out_tag[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    endtask

    // Transaction model: a request accepted at edge T yields a*b, visible from edge T+4
    // (T for a zero-skipped request), consumed at the first later edge with out_ready high.
    int unsigned cyc;
    bit          m_pend     [2];
    logic [15:0] m_p        [2];
    logic [1:0]  m_tag      [2];
    int unsigned m_due      [2];
    logic [15:0] m_last_p   [2];
    logic [1:0]  m_last_tag [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            for (int d = 0; d < 2; d++) begin
                m_pend[d]     = 1'b0;
                m_last_p[d]   = '0;
                m_last_tag[d] = '0;
            end
        end else begin
            cyc = cyc + 1;
            for (int d = 0; d < 2; d++) begin
                if (m_pend[d] && (cyc - 1 >= m_due[d]) && out_ready[d]) begin
                    m_pend[d] = 1'b0;
                end else if (!m_pend[d] && in_valid[d]) begin
                    m_pend[d] = 1'b1;
                    m_p[d]    = 16'(in_a[d]) * 16'(in_b[d]);
                    m_tag[d]  = in_tag[d];
                    m_due[d]  = (d == 0 && (in_a[d] == 0 || in_b[d] == 0)) ? cyc : cyc + 4;
                end
                if (m_pend[d] && cyc == m_due[d]) begin
                    m_last_p[d]   = m_p[d];
                    m_last_tag[d] = m_tag[d];
                end
            end
        end
    end

    // Per-cycle compare of every output of both instances against the model
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk("cyc_out_valid", d, out_valid[d], m_pend[d] && (cyc >= m_due[d]));
                chk("cyc_in_ready",  d, in_ready[d],  !m_pend[d]);
                chk("cyc_busy",      d, busy[d],      m_pend[d]);
                chk("cyc_out_p",     d, out_p[d],     m_last_p[d]);
                chk("cyc_out_tag",   d, out_tag[d],   m_last_tag[d]);
            end
        end
    end

    // Issue one request, wait for its result, pin latency/value/tag to literals
    task automatic run_req(input int d, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] tg, input logic [15:0] exp_p, input int exp_lat);
        int k;
        int lat;
        @(negedge clk);
        in_valid[d] = 1'b1; in_a[d] = a; in_b[d] = b; in_tag[d] = tg;
        k = 0;
        while (!in_ready[d] && k < 50) begin @(negedge clk); k++; end
        chk("accept_wait", d, k < 50, 1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0; in_a[d] = 8'($urandom); in_b[d] = 8'($urandom); in_tag[d] = 2'($urandom);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid[d] && lat < 20);
        chk("latency", d, lat, exp_lat);
        chk("out_p",   d, out_p[d], exp_p);
        chk("out_tag", d, out_tag[d], tg);
    endtask

    initial begin
        int k;
        int lat;
        int gap;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0; in_tag[d] = '0; out_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  0, in_ready[0],  1);
        chk("rst_out_valid", 0, out_valid[0], 0);
        chk("rst_out_p",     0, out_p[0],     16'h0000);
        chk("rst_busy",      0, busy[0],      0);
        rst_n = 1'b1;

        // Normal path, single-cycle valid with out_ready high
        run_req(0, 8'h12, 8'h34, 2'd1, 16'h03A8, 5);
        @(negedge clk);
        chk("valid_one_cycle", 0, out_valid[0], 0);

        // Maximum operands
        run_req(0, 8'hFF, 8'hFF, 2'd2, 16'hFE01, 5);

        // Zero operand with and without skip
        run_req(0, 8'h00, 8'h5A, 2'd3, 16'h0000, 1);
        run_req(1, 8'h00, 8'h5A, 2'd3, 16'h0000, 5);
        run_req(1, 8'h5A, 8'h00, 2'd1, 16'h0000, 5);

        // Backpressure: result held for 10 cycles
        out_ready[0] = 1'b0;
        run_req(0, 8'h9C, 8'h47, 2'd1, 16'h2B44, 5);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid",    0, out_valid[0], 1);
            chk("bp_p",        0, out_p[0],     16'h2B44);
            chk("bp_tag",      0, out_tag[0],   2'd1);
            chk("bp_in_ready", 0, in_ready[0],  0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 0, in_ready[0],  1);
        chk("bp_release_valid", 0, out_valid[0], 0);

        // Asynchronous reset during pass 2
        @(negedge clk);
        in_valid[0] = 1'b1; in_a[0] = 8'h77; in_b[0] = 8'h33; in_tag[0] = 2'd2;
        k = 0;
        while (!in_ready[0] && k < 50) begin @(negedge clk); k++; end
        chk("rst_accept_wait", 0, k < 50, 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 0, busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  0, in_ready[0],  1);
        chk("mid_rst_out_valid", 0, out_valid[0], 0);
        chk("mid_rst_out_p",     0, out_p[0],     16'h0000);
        chk("mid_rst_out_tag",   0, out_tag[0],   2'd0);
        chk("mid_rst_busy",      0, busy[0],      0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("no_stale_valid", 0, out_valid[0], 0);
        end

        // Back-to-back with in_valid held constant
        in_valid[0] = 1'b1; in_a[0] = 8'h0F; in_b[0] = 8'h0F; in_tag[0] = 2'd2;
        k = 0;
        while (!in_ready[0] && k < 50) begin @(negedge clk); k++; end
        chk("b2b_accept_wait", 0, k < 50, 1);
        @(posedge clk); #1;
        in_a[0] = 8'hA5; in_b[0] = 8'h3C; in_tag[0] = 2'd3;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid[0] && lat < 20);
        chk("b2b_lat1", 0, lat, 5);
        chk("b2b_p1",   0, out_p[0],   16'h00E1);
        chk("b2b_tag1", 0, out_tag[0], 2'd2);
        gap = 0;
        do begin @(negedge clk); gap++; end while (!out_valid[0] && gap < 20);
        in_valid[0] = 1'b0;
        chk("b2b_gap",  0, gap, 6);
        chk("b2b_p2",   0, out_p[0],   16'h26AC);
        chk("b2b_tag2", 0, out_tag[0], 2'd3);

        // Randomized traffic on both instances, checked by the per-cycle compare
        repeat (1500) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                in_valid[d]  = 1'($urandom_range(0, 1));
                in_a[d]      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                in_b[d]      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                in_tag[d]    = 2'($urandom);
                out_ready[d] = ($urandom_range(0, 3) != 0);
            end
        end
        for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
